// File: rtl/enemy_spawn_scheduler.sv
// enemy_spawn_scheduler
//
// Sequences the two falling enemy cars. After reset it parks both enemies
// off-screen, launches enemy 0 in the left lane and, after a stagger delay,
// enemy 1 in the right lane. Each enemy is respawned at a random lane/row
// when it reaches the despawn row. While running it ramps the speed offset
// handed to the enemy clock divider. A collision freezes everything until
// reset.
//
// Ports
//   enemy_clk                      scheduler clock
//   reset                          synchronous, active-high reset
//   collision_i                    collision level from the collision ALU
//   enemy_y0_i, enemy_y1_i         current y of enemy 0 / 1
//   rnd_x0_i, rnd_y0_i             random respawn position for enemy 0
//   rnd_x1_i, rnd_y1_i             random respawn position for enemy 1
//   spawn_en0_o, spawn_en1_o       one-cycle load strobe to enemy 0 / 1
//   spawn_x0_o, spawn_y0_o         load position for enemy 0 (held between strobes)
//   spawn_x1_o, spawn_y1_o         load position for enemy 1 (held between strobes)
//   accel_o                        speed offset to the enemy clock divider
//   rand_load_o                    LFSR seed load, high for every reset cycle
//   state_o                        PARK=0, WARMUP=1, RUN=2, CRASH=3

module enemy_spawn_scheduler #(
  parameter int unsigned LANE_LEFT    = 197,
  parameter int unsigned LANE_RIGHT   = 361,
  parameter int unsigned INITIAL_Y    = 0,
  parameter int unsigned PARK_Y       = 610,
  parameter int unsigned DESPAWN_Y    = 620,
  parameter int unsigned STAGGER      = 250,
  parameter int unsigned ACCEL_PERIOD = 500,
  parameter int unsigned ACCEL_STEP   = 1000,
  parameter int unsigned ACCEL_MAX    = 100000
) (
  input  logic        enemy_clk,
  input  logic        reset,
  input  logic        collision_i,
  input  logic [9:0]  enemy_y0_i,
  input  logic [9:0]  enemy_y1_i,
  input  logic [9:0]  rnd_x0_i,
  input  logic [9:0]  rnd_y0_i,
  input  logic [9:0]  rnd_x1_i,
  input  logic [9:0]  rnd_y1_i,
  output logic        spawn_en0_o,
  output logic        spawn_en1_o,
  output logic [9:0]  spawn_x0_o,
  output logic [9:0]  spawn_y0_o,
  output logic [9:0]  spawn_x1_o,
  output logic [9:0]  spawn_y1_o,
  output logic [24:0] accel_o,
  output logic        rand_load_o,
  output logic [1:0]  state_o
);

  // The tick counter serves both the launch stagger and the accel period.
  localparam int unsigned TickMax = (STAGGER > ACCEL_PERIOD) ? STAGGER : ACCEL_PERIOD;
  localparam int unsigned TickW   = $clog2(TickMax + 1);

  localparam logic [TickW-1:0] TickLaunch0 = TickW'(1);
  localparam logic [TickW-1:0] TickLaunch1 = TickW'(STAGGER);
  localparam logic [TickW-1:0] TickStep    = TickW'(ACCEL_PERIOD - 1);

  localparam logic [9:0]  LaneLeft  = 10'(LANE_LEFT);
  localparam logic [9:0]  LaneRight = 10'(LANE_RIGHT);
  localparam logic [9:0]  InitialY  = 10'(INITIAL_Y);
  localparam logic [9:0]  ParkY     = 10'(PARK_Y);
  localparam logic [9:0]  DespawnY  = 10'(DESPAWN_Y);
  localparam logic [24:0] AccelStep = 25'(ACCEL_STEP);
  localparam logic [24:0] AccelMax  = 25'(ACCEL_MAX);

  typedef enum logic [1:0] {
    StPark   = 2'd0,
    StWarmup = 2'd1,
    StRun    = 2'd2,
    StCrash  = 2'd3
  } state_e;

  state_e           state_q;
  logic [TickW-1:0] tick_q;
  logic [24:0]      accel_q;
  logic             launched1_q;
  logic             spawn_en0_q, spawn_en1_q;
  logic [9:0]       spawn_x0_q, spawn_y0_q, spawn_x1_q, spawn_y1_q;
  logic             rand_load_q;

  logic        despawn0, despawn1;
  logic [24:0] accel_sum, accel_next;

  // Enemy 1 sits at whatever y it had before launch; only trust its despawn
  // row once it has actually been launched.
  assign despawn0 = (enemy_y0_i == DespawnY);
  assign despawn1 = (enemy_y1_i == DespawnY) && launched1_q;

  // Wraps to zero instead of saturating so the difficulty ramp cycles.
  assign accel_sum  = accel_q + AccelStep;
  assign accel_next = (accel_sum >= AccelMax) ? 25'd0 : accel_sum;

  always_ff @(posedge enemy_clk) begin
    if (reset) begin
      state_q     <= StPark;
      tick_q      <= '0;
      accel_q     <= '0;
      launched1_q <= 1'b0;
      spawn_en0_q <= 1'b0;
      spawn_en1_q <= 1'b0;
      spawn_x0_q  <= LaneLeft;
      spawn_y0_q  <= ParkY;
      spawn_x1_q  <= LaneRight;
      spawn_y1_q  <= ParkY;
      rand_load_q <= 1'b1;
    end else begin
      rand_load_q <= 1'b0;
      spawn_en0_q <= 1'b0;
      spawn_en1_q <= 1'b0;

      unique case (state_q)
        StPark: begin
          state_q <= StWarmup;
          tick_q  <= '0;
        end

        StWarmup: begin
          if (collision_i) begin
            state_q <= StCrash;
          end else begin
            tick_q <= tick_q + 1'b1;

            // A launch on a lane takes precedence over its respawn.
            if (tick_q == TickLaunch0) begin
              spawn_en0_q <= 1'b1;
              spawn_x0_q  <= LaneLeft;
              spawn_y0_q  <= InitialY;
            end else if (despawn0) begin
              spawn_en0_q <= 1'b1;
              spawn_x0_q  <= rnd_x0_i;
              spawn_y0_q  <= rnd_y0_i;
            end

            if (tick_q == TickLaunch1) begin
              spawn_en1_q <= 1'b1;
              spawn_x1_q  <= LaneRight;
              spawn_y1_q  <= InitialY;
              launched1_q <= 1'b1;
              state_q     <= StRun;
              tick_q      <= '0;
            end else if (despawn1) begin
              spawn_en1_q <= 1'b1;
              spawn_x1_q  <= rnd_x1_i;
              spawn_y1_q  <= rnd_y1_i;
            end
          end
        end

        StRun: begin
          if (collision_i) begin
            state_q <= StCrash;
          end else begin
            if (tick_q == TickStep) begin
              tick_q  <= '0;
              accel_q <= accel_next;
            end else begin
              tick_q <= tick_q + 1'b1;
            end

            if (despawn0) begin
              spawn_en0_q <= 1'b1;
              spawn_x0_q  <= rnd_x0_i;
              spawn_y0_q  <= rnd_y0_i;
            end

            if (despawn1) begin
              spawn_en1_q <= 1'b1;
              spawn_x1_q  <= rnd_x1_i;
              spawn_y1_q  <= rnd_y1_i;
            end
          end
        end

        StCrash: begin
          // Terminal until reset; tick, accel and positions hold.
          state_q <= StCrash;
        end

        default: state_q <= StPark;
      endcase
    end
  end

  assign spawn_en0_o = spawn_en0_q;
  assign spawn_en1_o = spawn_en1_q;
  assign spawn_x0_o  = spawn_x0_q;
  assign spawn_y0_o  = spawn_y0_q;
  assign spawn_x1_o  = spawn_x1_q;
  assign spawn_y1_o  = spawn_y1_q;
  assign accel_o     = accel_q;
  assign rand_load_o = rand_load_q;
  assign state_o     = state_q;

endmodule
